// File: rtl/softmax_row_collector_if.sv
// rtl/softmax_row_collector_if.sv - tile input and column output handshake bundle
interface softmax_row_collector_if #(
  parameter int WIDTH     = 16,
  parameter int TILE_SIZE = 4,
  parameter int NUM_ROWS  = 8
);
  logic [TILE_SIZE*WIDTH-1:0] in_data [NUM_ROWS];
  logic [NUM_ROWS-1:0]        in_valid;
  logic                       in_ready;
  logic [NUM_ROWS*WIDTH-1:0]  out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/softmax_row_collector.sv
// rtl/softmax_row_collector.sv - ping-pong softmax row collector with column-wise drain
module softmax_row_collector #(
  parameter int WIDTH     = 16,
  parameter int TILE_SIZE = 4,
  parameter int NUM_ROWS  = 8,
  parameter int ROW_LEN   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  softmax_row_collector_if.slave bus,
  output logic [1:0]             bank_full,
  output logic                   overflow_err
);
  localparam int TPR  = ROW_LEN / TILE_SIZE;
  localparam int CW   = $clog2(TPR + 1);
  localparam int COLW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state, state_nxt;
  logic [WIDTH-1:0]          mem [2][NUM_ROWS][ROW_LEN];
  logic                      wr_bank, rd_bank;
  logic [CW-1:0]             tile_cnt [NUM_ROWS];
  logic [CW-1:0]             cnt_nxt [NUM_ROWS];
  logic [COLW-1:0]           rd_col;
  logic [NUM_ROWS-1:0]       accept, drop;
  logic                      in_ready, complete, handshake, col_last;
  logic [1:0]                set_full, clr_full;
  logic [NUM_ROWS*WIDTH-1:0] col_data;

  assign in_ready     = ~bank_full[wr_bank];
  assign bus.in_ready = in_ready;

  // Completion looks at the counts including writes landing on this edge.
  always_comb begin
    accept   = '0;
    drop     = '0;
    complete = in_ready;
    for (int r = 0; r < NUM_ROWS; r++) begin
      accept[r]  = bus.in_valid[r] && in_ready && (tile_cnt[r] < CW'(TPR));
      drop[r]    = bus.in_valid[r] && !accept[r];
      cnt_nxt[r] = tile_cnt[r] + CW'(accept[r]);
      if (cnt_nxt[r] != CW'(TPR)) complete = 1'b0;
    end
  end

  assign col_last  = (rd_col == COLW'(ROW_LEN - 1));
  assign handshake = (state == STREAM) && bus.out_ready;

  always_comb begin
    set_full = '0;
    clr_full = '0;
    if (complete) set_full[wr_bank] = 1'b1;
    if (handshake && col_last) clr_full[rd_bank] = 1'b1;
  end

  // Looking ahead at set_full gives out_valid the cycle after completion and no bubble between banks.
  always_comb begin
    state_nxt     = state;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    col_data      = '0;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank] || set_full[rd_bank]) state_nxt = STREAM;
      end
      STREAM: begin
        bus.out_valid = 1'b1;
        bus.out_last  = col_last;
        for (int r = 0; r < NUM_ROWS; r++) col_data[r*WIDTH +: WIDTH] = mem[rd_bank][r][rd_col];
        if (handshake && col_last)
          state_nxt = (bank_full[~rd_bank] || set_full[~rd_bank]) ? STREAM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.out_data = col_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bank_full    <= '0;
      overflow_err <= 1'b0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      rd_col       <= '0;
      for (int r = 0; r < NUM_ROWS; r++) tile_cnt[r] <= '0;
    end else begin
      state        <= state_nxt;
      bank_full    <= (bank_full | set_full) & ~clr_full;
      overflow_err <= overflow_err | (|drop);
      if (complete) wr_bank <= ~wr_bank;
      for (int r = 0; r < NUM_ROWS; r++) tile_cnt[r] <= complete ? '0 : cnt_nxt[r];
      if (handshake) begin
        rd_col <= col_last ? '0 : rd_col + COLW'(1);
        if (col_last) rd_bank <= ~rd_bank;
      end
    end
  end

  // Bank storage carries no reset; contents are only read once a bank is complete.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (accept[r]) begin
        for (int k = 0; k < TILE_SIZE; k++)
          mem[wr_bank][r][COLW'(int'(tile_cnt[r]) * TILE_SIZE + k)] <= bus.in_data[r][k*WIDTH +: WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_softmax_row_collector.sv
// tb/tb_softmax_row_collector.sv - randomized self-checking bench against a block-queue model
module tb_softmax_row_collector;
  localparam int W = 16, T = 4, NR = 8, RL = 16;
  localparam int BLK = NR * RL * W;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] bank_full;
  logic overflow_err;

  softmax_row_collector_if #(.WIDTH(W), .TILE_SIZE(T), .NUM_ROWS(NR)) ifc ();

  softmax_row_collector #(.WIDTH(W), .TILE_SIZE(T), .NUM_ROWS(NR), .ROW_LEN(RL)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (ifc.slave),
    .bank_full    (bank_full),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: completed blocks waiting to drain, the block being assembled, and per-lane element counts.
  logic [BLK-1:0] blkq[$];
  logic [BLK-1:0] cur;
  logic [BLK-1:0] head;
  int             lane_n [NR];
  int             col;
  int             drained;
  bit             m_ovf;
  logic [T*W-1:0] tile [NR];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    blkq.delete();
    cur = '0;
    for (int r = 0; r < NR; r++) lane_n[r] = 0;
    col = 0;
    drained = 0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    ifc.in_valid  = '0;
    ifc.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  function automatic logic [T*W-1:0] make_rc(input int r, input int tidx);
    logic [T*W-1:0] v;
    for (int k = 0; k < T; k++) v[k*W +: W] = W'((r << 8) | (tidx * T + k));
    return v;
  endfunction

  task automatic step(input logic [NR-1:0] v, input logic ordy);
    int                 pending;
    bit                 e_ready, e_valid, full_lanes;
    logic [NR*W-1:0]    e_data;
    logic [1:0]         e_bf;
    ifc.in_valid  = v;
    ifc.out_ready = ordy;
    for (int r = 0; r < NR; r++) ifc.in_data[r] = tile[r];
    @(negedge clk);
    pending = blkq.size();
    e_ready = (pending < 2);
    e_valid = (pending > 0);
    e_data  = '0;
    if (e_valid) begin
      head = blkq[0];
      for (int r = 0; r < NR; r++) e_data[r*W +: W] = head[(r*RL + col)*W +: W];
    end
    e_bf = (pending == 0) ? 2'b00 : (pending == 2) ? 2'b11 : (drained % 2 == 1) ? 2'b10 : 2'b01;
    chk("in_ready", 128'(ifc.in_ready), 128'(e_ready));
    chk("out_valid", 128'(ifc.out_valid), 128'(e_valid));
    chk("out_data", 128'(ifc.out_data), 128'(e_data));
    chk("out_last", 128'(ifc.out_last), 128'(e_valid && col == RL - 1));
    chk("bank_full", 128'(bank_full), 128'(e_bf));
    chk("overflow_err", 128'(overflow_err), 128'(m_ovf));
    @(posedge clk);
    if (e_valid && ordy) begin
      col++;
      if (col == RL) begin
        void'(blkq.pop_front());
        col = 0;
        drained++;
      end
    end
    for (int r = 0; r < NR; r++) begin
      if (v[r]) begin
        if (e_ready && lane_n[r] < RL / T) begin
          for (int k = 0; k < T; k++) cur[(r*RL + lane_n[r]*T + k)*W +: W] = tile[r][k*W +: W];
          lane_n[r]++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    full_lanes = 1'b1;
    for (int r = 0; r < NR; r++) if (lane_n[r] != RL / T) full_lanes = 1'b0;
    if (full_lanes) begin
      blkq.push_back(cur);
      for (int r = 0; r < NR; r++) lane_n[r] = 0;
    end
    #1;
  endtask

  task automatic rand_tiles();
    for (int r = 0; r < NR; r++) tile[r] = {$urandom, $urandom};
  endtask

  initial begin
    int sent [NR];
    int nxt  [NR];
    int cyc;
    bit busy;
    logic [NR-1:0] v;

    for (int r = 0; r < NR; r++) begin
      ifc.in_data[r] = '0;
      tile[r] = '0;
    end
    do_reset();

    // Single bank with {row,col} elements
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < NR; r++) tile[r] = make_rc(r, t);
      step('1, 1'b1);
    end
    repeat (20) step('0, 1'b1);

    // Staggered lanes with random gaps
    for (int r = 0; r < NR; r++) begin
      sent[r] = 0;
      nxt[r] = 2 * r;
    end
    cyc = 0;
    busy = 1'b1;
    while (busy && cyc < 200) begin
      v = '0;
      busy = 1'b0;
      for (int r = 0; r < NR; r++) begin
        if (sent[r] < 4 && cyc >= nxt[r]) begin
          v[r] = 1'b1;
          tile[r] = make_rc(r, sent[r]);
          sent[r]++;
          nxt[r] = cyc + 1 + $urandom_range(0, 2);
        end
        if (sent[r] < 4) busy = 1'b1;
      end
      step(v, 1'b1);
      cyc++;
    end
    repeat (20) step('0, 1'b1);

    // Two banks with output stalled, then a ninth tile cycle that must be dropped
    for (int t = 0; t < 9; t++) begin
      rand_tiles();
      step('1, 1'b0);
    end
    repeat (40) step('0, 1'b1);

    // Lane 3 overruns its row before the others finish
    do_reset();
    for (int t = 0; t < 5; t++) begin
      tile[3] = make_rc(3, t);
      step(NR'(8), 1'b1);
    end
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < NR; r++) tile[r] = make_rc(r, t);
      step(~NR'(8), 1'b1);
    end
    repeat (20) step('0, 1'b1);

    // Random traffic with random backpressure
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rand_tiles();
      step(NR'($urandom_range(0, 255) & $urandom_range(0, 255) | $urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    repeat (60) step('0, 1'b1);

    // Reset at column 7 of bank 0 while bank 1 is half filled
    do_reset();
    for (int t = 0; t < 4; t++) begin
      rand_tiles();
      step('1, 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      rand_tiles();
      step((i < 2) ? '1 : '0, 1'b1);
    end
    do_reset();
    step('0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < NR; r++) tile[r] = make_rc(r, t);
      step('1, 1'b1);
    end
    repeat (20) step('0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
